// File: rtl/keyboard_decoder_if.sv
// Producer/consumer handshake carrying decoded keyboard operations to game logic.
interface keyboard_decoder_if;
  logic       keyboard_ready;
  logic [2:0] keyboard_data;
  logic       keyboard_read_fin;

  modport master (
    output keyboard_ready,
    output keyboard_data,
    input  keyboard_read_fin
  );

  modport slave (
    input  keyboard_ready,
    input  keyboard_data,
    output keyboard_read_fin
  );
endinterface

// File: rtl/keyboard_decoder.sv
// PS/2 Set-2 frame receiver and game-operation decoder with a one-deep pending slot.
// Optional feature macro: KEYBOARD_ARROW_EN (extended arrow make codes map to W/A/S/D).
module keyboard_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ps2_clock,
  input  logic                ps2_data,
  keyboard_decoder_if.master  kb,
  output logic                frame_error
);

  localparam int unsigned OP_W  = 3;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [OP_W-1:0] OP_KEY_W = OP_W'(0);
  localparam logic [OP_W-1:0] OP_KEY_A = OP_W'(1);
  localparam logic [OP_W-1:0] OP_KEY_S = OP_W'(2);
  localparam logic [OP_W-1:0] OP_KEY_D = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SPACE = OP_W'(4);
  localparam logic [OP_W-1:0] OP_KEY_Z = OP_W'(5);
  localparam logic [OP_W-1:0] OP_NONE  = OP_W'(6);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // Pin synchronizers and falling-edge detect on the synchronized PS/2 clock
  logic [1:0] clk_sync;
  logic [1:0] dat_sync;
  logic       clk_prev;
  logic       fall_c;
  logic       bit_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clock};
      dat_sync <= {dat_sync[0], ps2_data};
      clk_prev <= clk_sync[1];
    end
  end

  assign fall_c = clk_prev & ~clk_sync[1];
  assign bit_c  = dat_sync[1];

  // Cycles since the last PS/2 falling edge, saturating at the timeout
  logic [CNT_W-1:0] idle_cnt;
  state_t           state;
  state_t           state_d;
  logic             timeout_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (fall_c) begin
      idle_cnt <= '0;
    end else if (idle_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end

  assign timeout_c = (idle_cnt == CNT_W'(TIMEOUT_CYCLES)) && (state != ST_IDLE);

  function automatic logic [OP_W:0] map_code(input logic [7:0] code, input logic is_ext);
    map_code = {1'b0, OP_NONE};
    if (!is_ext) begin
      case (code)
        8'h1D:   map_code = {1'b1, OP_KEY_W};
        8'h1C:   map_code = {1'b1, OP_KEY_A};
        8'h1B:   map_code = {1'b1, OP_KEY_S};
        8'h23:   map_code = {1'b1, OP_KEY_D};
        8'h29:   map_code = {1'b1, OP_SPACE};
        8'h1A:   map_code = {1'b1, OP_KEY_Z};
        default: map_code = {1'b0, OP_NONE};
      endcase
    end
`ifdef KEYBOARD_ARROW_EN
    else begin
      case (code)
        8'h75:   map_code = {1'b1, OP_KEY_W};
        8'h6B:   map_code = {1'b1, OP_KEY_A};
        8'h72:   map_code = {1'b1, OP_KEY_S};
        8'h74:   map_code = {1'b1, OP_KEY_D};
        default: map_code = {1'b0, OP_NONE};
      endcase
    end
`endif
  endfunction

  logic [2:0]      bit_cnt,   bit_cnt_d;
  logic [7:0]      shift,     shift_d;
  logic            parity,    parity_d;
  logic            ext,       ext_d;
  logic            brk,       brk_d;
  logic            err_d;
  logic            dec_valid, dec_valid_d;
  logic [OP_W-1:0] dec_op,    dec_op_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      parity      <= 1'b0;
      ext         <= 1'b0;
      brk         <= 1'b0;
      frame_error <= 1'b0;
      dec_valid   <= 1'b0;
      dec_op      <= OP_NONE;
    end else begin
      state       <= state_d;
      bit_cnt     <= bit_cnt_d;
      shift       <= shift_d;
      parity      <= parity_d;
      ext         <= ext_d;
      brk         <= brk_d;
      frame_error <= err_d;
      dec_valid   <= dec_valid_d;
      dec_op      <= dec_op_d;
    end
  end

  // Frame FSM; a good stop edge also runs the prefix tracking and make-code decode
  always_comb begin
    state_d     = state;
    bit_cnt_d   = bit_cnt;
    shift_d     = shift;
    parity_d    = parity;
    ext_d       = ext;
    brk_d       = brk;
    err_d       = 1'b0;
    dec_valid_d = 1'b0;
    dec_op_d    = OP_NONE;
    if (fall_c) begin
      case (state)
        ST_IDLE: begin
          if (!bit_c) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {bit_c, shift[7:1]};
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_d = bit_c;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (bit_c && (^{shift, parity})) begin
            if (shift == 8'hE0) begin
              ext_d = 1'b1;
            end else if (shift == 8'hF0) begin
              brk_d = 1'b1;
            end else begin
              ext_d = 1'b0;
              brk_d = 1'b0;
              if (!brk) {dec_valid_d, dec_op_d} = map_code(shift, ext);
            end
          end else begin
            err_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout_c) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
    end
  end

  // Output register, pending slot and re-arm guard (armed = read_fin seen low since retire)
  logic            ready_q,    ready_d;
  logic [OP_W-1:0] data_q,     data_d;
  logic            pend_valid, pend_valid_d;
  logic [OP_W-1:0] pend_op,    pend_op_d;
  logic            armed,      armed_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_q    <= 1'b0;
      data_q     <= OP_NONE;
      pend_valid <= 1'b0;
      pend_op    <= OP_NONE;
      armed      <= 1'b1;
    end else begin
      ready_q    <= ready_d;
      data_q     <= data_d;
      pend_valid <= pend_valid_d;
      pend_op    <= pend_op_d;
      armed      <= armed_d;
    end
  end

  always_comb begin
    ready_d      = ready_q;
    data_d       = data_q;
    pend_valid_d = pend_valid;
    pend_op_d    = pend_op;
    armed_d      = armed;
    if (ready_q && kb.keyboard_read_fin) begin
      ready_d = 1'b0;
      data_d  = OP_NONE;
      armed_d = 1'b0;
      if (dec_valid && !pend_valid) begin
        pend_valid_d = 1'b1;
        pend_op_d    = dec_op;
      end
    end else if (!ready_q && (armed || !kb.keyboard_read_fin)) begin
      armed_d = 1'b1;
      if (pend_valid) begin
        ready_d      = 1'b1;
        data_d       = pend_op;
        pend_valid_d = dec_valid;
        if (dec_valid) pend_op_d = dec_op;
      end else if (dec_valid) begin
        ready_d = 1'b1;
        data_d  = dec_op;
      end
    end else if (dec_valid && !pend_valid) begin
      pend_valid_d = 1'b1;
      pend_op_d    = dec_op;
    end
  end

  assign kb.keyboard_ready = ready_q;
  assign kb.keyboard_data  = data_q;

endmodule
